// File: rtl/scan_latch_ctrl_if.sv
// Configuration/scan handshake bundle for scan_latch_ctrl.
// master = controller user (drives config and chain return), slave = scan_latch_ctrl.
interface scan_latch_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             io_cfg_valid;
    logic             io_cfg_ready;
    logic [WIDTH-1:0] io_cfg_data;
    logic             io_clear;
    logic             io_scan_en;
    logic             io_scan_out;
    logic             io_scan_in;
    logic             io_latch_en;
    logic             io_latch_rst;
    logic             io_done;
    logic [WIDTH-1:0] io_rdata;

    modport master (
        output io_cfg_valid, io_cfg_data, io_clear, io_scan_in,
        input  io_cfg_ready, io_scan_en, io_scan_out, io_latch_en,
               io_latch_rst, io_done, io_rdata
    );

    modport slave (
        input  io_cfg_valid, io_cfg_data, io_clear, io_scan_in,
        output io_cfg_ready, io_scan_en, io_scan_out, io_latch_en,
               io_latch_rst, io_done, io_rdata
    );
endinterface

// File: rtl/scan_latch_ctrl.sv
// Serial scan-chain loader with latch-bank update/clear sequencing.
// Optional chain readback into io_rdata is enabled by SCAN_LATCH_CTRL_READBACK_EN.
module scan_latch_ctrl #(
    parameter int WIDTH         = 8,
    parameter int UPDATE_CYCLES = 2
) (
    input  logic              io_clk,
    input  logic              io_rst,
    scan_latch_ctrl_if.slave  bus
);
    localparam int MAXC = (WIDTH > UPDATE_CYCLES) ? WIDTH : UPDATE_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_UPDATE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             shift_in;
    logic             idle_q;
    logic             scan_en_q;
    logic             scan_out_q;
    logic             latch_en_q;
    logic             latch_rst_q;
    logic             done_q;

    assign sr_d[0] = shift_in;
    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign sr_d[gi] = sr_q[gi-1];
        end
    endgenerate

    // Ready tracks the input clear and reset directly so a clear request wins the same cycle.
    assign bus.io_cfg_ready = idle_q & ~bus.io_clear & ~io_rst;
    assign bus.io_scan_en   = scan_en_q;
    assign bus.io_scan_out  = scan_out_q;
    assign bus.io_latch_en  = latch_en_q;
    assign bus.io_latch_rst = latch_rst_q;
    assign bus.io_done      = done_q;

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            idle_q      <= 1'b1;
            scan_en_q   <= 1'b0;
            scan_out_q  <= 1'b0;
            latch_en_q  <= 1'b0;
            latch_rst_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.io_clear) begin
                        state_q     <= S_CLEAR;
                        idle_q      <= 1'b0;
                        latch_rst_q <= 1'b1;
                    end else if (bus.io_cfg_valid) begin
                        state_q    <= S_SHIFT;
                        idle_q     <= 1'b0;
                        sr_q       <= bus.io_cfg_data;
                        cnt_q      <= CW'(WIDTH - 1);
                        scan_en_q  <= 1'b1;
                        scan_out_q <= bus.io_cfg_data[WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    sr_q <= sr_d;
                    if (cnt_q == '0) begin
                        state_q    <= S_UPDATE;
                        cnt_q      <= CW'(UPDATE_CYCLES - 1);
                        scan_en_q  <= 1'b0;
                        scan_out_q <= 1'b0;
                        latch_en_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q - 1'b1;
                        scan_out_q <= sr_d[WIDTH-1];
                    end
                end
                S_UPDATE: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_DONE;
                        latch_en_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q     <= S_DONE;
                    latch_rst_q <= 1'b0;
                    done_q      <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    idle_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

`ifdef SCAN_LATCH_CTRL_READBACK_EN
    logic [WIDTH-1:0] rdata_q;

    assign shift_in     = bus.io_scan_in;
    assign bus.io_rdata = rdata_q;

    // Snapshot the chain contents including the bit sampled on the final shift edge.
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            rdata_q <= '0;
        end else if (state_q == S_SHIFT && cnt_q == '0) begin
            rdata_q <= sr_d;
        end
    end
`else
    // Chain return is masked off; zeros fill the LSB.
    assign shift_in     = bus.io_scan_in & 1'b0;
    assign bus.io_rdata = '0;
`endif

endmodule
